// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump unit: resolves JAL/JALR/conditional branches with a
// valid/ready issue port, LATENCY-deep tagged pipe, backpressure and flush.
module fu_branch_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             is_jump,
  input  logic             jalr,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [TAG_W-1:0] done_tag,
  output logic [XLEN-1:0]  pc_jump,
  output logic [XLEN-1:0]  pc_wb,
  output logic             taken,
  output logic             mispredict,
  output logic             misaligned
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  pc_jump;
    logic [XLEN-1:0]  pc_wb;
    logic             taken;
    logic             mispredict;
    logic             misaligned;
  } res_t;

  logic            w_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic            w_stall;
  res_t            w_res;

  logic            r_valid [LATENCY];
  res_t            r_stage [LATENCY];

  always_comb begin
    w_cond = 1'b0;
    unique case (cmp_ctrl)
      3'b001:  w_cond = (rs1_data == rs2_data);
      3'b010:  w_cond = (rs1_data != rs2_data);
      3'b011:  w_cond = ($signed(rs1_data) < $signed(rs2_data));
      3'b100:  w_cond = (rs1_data < rs2_data);
      3'b101:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_cond = (rs1_data >= rs2_data);
      default: w_cond = 1'b0;
    endcase
    w_taken  = is_jump | w_cond;
    w_base   = jalr ? rs1_data : pc;
    w_sum    = w_base + imm;
    w_target = jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    w_res            = '0;
    w_res.tag        = issue_tag;
    w_res.pc_jump    = w_target;
    w_res.pc_wb      = pc + XLEN'(4);
    w_res.taken      = w_taken;
    w_res.misaligned = w_taken & w_target[1];
    w_res.mispredict = (w_taken != pred_taken) |
                       (w_taken & pred_taken & (w_target != pred_target));
  end

  // Whole pipe freezes while the last stage holds an unaccepted result.
  assign w_stall     = r_valid[LATENCY-1] & ~done_ready;
  assign issue_ready = ~flush & ~w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_valid[i] <= 1'b0;
        r_stage[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= issue_valid;
      if (issue_valid) begin
        r_stage[0] <= w_res;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign done_valid = r_valid[LATENCY-1];
  assign done_tag   = r_stage[LATENCY-1].tag;
  assign pc_jump    = r_stage[LATENCY-1].pc_jump;
  assign pc_wb      = r_stage[LATENCY-1].pc_wb;
  assign taken      = r_stage[LATENCY-1].taken;
  assign mispredict = r_stage[LATENCY-1].mispredict;
  assign misaligned = r_stage[LATENCY-1].misaligned;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Bench for fu_branch_pipe: LATENCY=2 unit checked cycle by cycle against an
// in-order queue model; LATENCY=1 and 4 units share inputs for latency checks.
module tb_fu_branch_pipe;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 2;

  logic             clk = 1'b0;
  logic             rst, flush, issue_valid, is_jump, jalr, pred_taken, done_ready;
  logic [TAG_W-1:0] issue_tag;
  logic [2:0]       cmp_ctrl;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc, pred_target;

  logic             issue_ready, done_valid, taken, mispredict, misaligned;
  logic [TAG_W-1:0] done_tag;
  logic [XLEN-1:0]  pc_jump, pc_wb;

  logic             rdy_l1, dv_l1, tk_l1, mp_l1, ma_l1;
  logic [TAG_W-1:0] tag_l1;
  logic [XLEN-1:0]  pj_l1, pw_l1;
  logic             rdy_l4, dv_l4, tk_l4, mp_l4, ma_l4;
  logic [TAG_W-1:0] tag_l4;
  logic [XLEN-1:0]  pj_l4, pw_l4;

  always #5 clk = ~clk;

  fu_branch_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_tag(issue_tag), .is_jump(is_jump),
    .jalr(jalr), .cmp_ctrl(cmp_ctrl), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
    .pc_jump(pc_jump), .pc_wb(pc_wb), .taken(taken), .mispredict(mispredict),
    .misaligned(misaligned));

  fu_branch_pipe #(.XLEN(XLEN), .LATENCY(1), .TAG_W(TAG_W)) u_dut_l1 (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(rdy_l1), .issue_tag(issue_tag), .is_jump(is_jump),
    .jalr(jalr), .cmp_ctrl(cmp_ctrl), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .done_valid(dv_l1), .done_ready(done_ready), .done_tag(tag_l1),
    .pc_jump(pj_l1), .pc_wb(pw_l1), .taken(tk_l1), .mispredict(mp_l1),
    .misaligned(ma_l1));

  fu_branch_pipe #(.XLEN(XLEN), .LATENCY(4), .TAG_W(TAG_W)) u_dut_l4 (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(rdy_l4), .issue_tag(issue_tag), .is_jump(is_jump),
    .jalr(jalr), .cmp_ctrl(cmp_ctrl), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .done_valid(dv_l4), .done_ready(done_ready), .done_tag(tag_l4),
    .pc_jump(pj_l4), .pc_wb(pw_l4), .taken(tk_l4), .mispredict(mp_l4),
    .misaligned(ma_l4));

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             jmp, jr, pd;
    logic [2:0]       cmp;
    logic [31:0]      rs1, rs2, imm, pc, pt;
  } op_t;

  typedef struct {
    logic [31:0] tgt, link;
    logic        tk, mp, ma;
  } res_t;

  int               n_total = 0;
  int               n_bad   = 0;
  op_t              q_op[$];
  int               q_adv[$];
  logic [TAG_W-1:0] delivered[$];
  logic             last_acc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic res_t ref_model(input op_t o);
    res_t        r;
    logic        c;
    logic [31:0] sum;
    case (o.cmp)
      3'd1:    c = (o.rs1 == o.rs2);
      3'd2:    c = (o.rs1 != o.rs2);
      3'd3:    c = ($signed(o.rs1) < $signed(o.rs2));
      3'd4:    c = (o.rs1 < o.rs2);
      3'd5:    c = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6:    c = (o.rs1 >= o.rs2);
      default: c = 1'b0;
    endcase
    r.tk   = o.jmp | c;
    sum    = (o.jr ? o.rs1 : o.pc) + o.imm;
    r.tgt  = o.jr ? (sum & ~32'h1) : sum;
    r.link = o.pc + 32'd4;
    r.ma   = r.tk & r.tgt[1];
    r.mp   = (r.tk != o.pd) || (r.tk && o.pd && (r.tgt != o.pt));
    return r;
  endfunction

  function automatic op_t cur_op();
    op_t o;
    o.tag = issue_tag; o.jmp = is_jump; o.jr = jalr; o.pd = pred_taken;
    o.cmp = cmp_ctrl;  o.rs1 = rs1_data; o.rs2 = rs2_data; o.imm = imm;
    o.pc  = pc;        o.pt  = pred_target;
    return o;
  endfunction

  // Check current outputs against the model, then advance the model over the coming edge.
  task automatic step();
    logic exp_dv, stall;
    res_t e;
    @(negedge clk);
    exp_dv = (q_op.size() > 0) && (q_adv[0] == LATENCY);
    stall  = exp_dv && !done_ready;
    chk("done_valid", done_valid, exp_dv);
    chk("issue_ready", issue_ready, !flush && !stall);
    if (exp_dv) begin
      e = ref_model(q_op[0]);
      chk("done_tag", done_tag, q_op[0].tag);
      chk("pc_jump", pc_jump, e.tgt);
      chk("pc_wb", pc_wb, e.link);
      chk("taken", taken, e.tk);
      chk("mispredict", mispredict, e.mp);
      chk("misaligned", misaligned, e.ma);
    end
    if (done_valid && done_ready) delivered.push_back(done_tag);
    last_acc = issue_valid && !flush && !stall;
    if (flush) begin
      q_op.delete();
      q_adv.delete();
    end else if (!stall) begin
      if (exp_dv) begin
        void'(q_op.pop_front());
        void'(q_adv.pop_front());
      end
      foreach (q_adv[i]) q_adv[i]++;
      if (issue_valid) begin
        q_op.push_back(cur_op());
        q_adv.push_back(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one();
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    repeat (LATENCY - 1) step();
  endtask

  task automatic set_op(input logic [TAG_W-1:0] t, input logic j, input logic jr,
                        input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p,
                        input logic pd, input logic [31:0] pt);
    issue_tag = t; is_jump = j; jalr = jr; cmp_ctrl = c; rs1_data = a; rs2_data = b;
    imm = im; pc = p; pred_taken = pd; pred_target = pt;
  endtask

  initial begin
    int   t, lat1, lat2, lat4;
    op_t  o;
    res_t r;

    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; done_ready = 1'b1;
    set_op('0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
    #3;
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_pc_jump", pc_jump, 0);
    chk("rst_pc_wb", pc_wb, 0);
    chk("rst_flags", {taken, mispredict, misaligned}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_issue_ready", issue_ready, 1);

    // Directed: BEQ taken, predicted not-taken.
    set_op(4'd3, 1'b0, 1'b0, 3'b001, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0);
    issue_one();
    chk("t1_valid", done_valid, 1);
    chk("t1_tag", done_tag, 3);
    chk("t1_taken", taken, 1);
    chk("t1_target", pc_jump, 32'h120);
    chk("t1_link", pc_wb, 32'h104);
    chk("t1_mispred", mispredict, 1);

    // JALR clears bit 0, target still misaligned on bit 1.
    set_op(4'd5, 1'b1, 1'b1, 3'b000, 32'h1003, 32'h0, 32'h4, 32'h200, 1'b1, 32'h1006);
    issue_one();
    chk("t2_target", pc_jump, 32'h1006);
    chk("t2_taken", taken, 1);
    chk("t2_mispred", mispredict, 0);
    chk("t2_misalign", misaligned, 1);
    pred_target = 32'h1008;
    issue_one();
    chk("t2b_mispred", mispredict, 1);

    set_op(4'd6, 1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h8, 32'hFFFF_FFFC, 1'b0, 32'h0);
    issue_one();
    chk("t3_lt", taken, 1);
    chk("t3_wrap_target", pc_jump, 32'h4);
    chk("t3_wrap_link", pc_wb, 32'h0);
    cmp_ctrl = 3'b100;
    issue_one();
    chk("t3_ltu", taken, 0);
    cmp_ctrl = 3'b000;
    issue_one();
    chk("t3_none", taken, 0);
    repeat (3) step();

    // Backpressure: hold each tag until accepted.
    delivered.delete();
    done_ready = 1'b0;
    t = 1;
    for (int k = 0; k < 8 && t <= 4; k++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(t);
      step();
      if (last_acc) t++;
    end
    chk("bp_ready_low", issue_ready, 0);
    chk("bp_accepted", t, 3);
    done_ready = 1'b1;
    for (int k = 0; k < 8 && t <= 4; k++) begin
      issue_valid = 1'b1; issue_tag = TAG_W'(t);
      step();
      if (last_acc) t++;
    end
    issue_valid = 1'b0;
    repeat (5) step();
    chk("bp_count", delivered.size(), 4);
    foreach (delivered[i]) chk("bp_order", delivered[i], i + 1);

    // Flush during a stall drops both in-flight tags.
    delivered.delete();
    done_ready = 1'b0;
    issue_valid = 1'b1; issue_tag = 4'd7; step();
    issue_tag = 4'd8; step();
    flush = 1'b1; issue_tag = 4'd9;
    chk("fl_ready", issue_ready, 0);
    step();
    flush = 1'b0; done_ready = 1'b1; issue_tag = 4'd10;
    step();
    issue_valid = 1'b0;
    repeat (4) step();
    chk("fl_count", delivered.size(), 1);
    if (delivered.size() > 0) chk("fl_tag", delivered[0], 10);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      issue_valid = ($urandom % 4) != 0;
      flush       = ($urandom % 20) == 0;
      done_ready  = ($urandom % 4) != 0;
      issue_tag   = TAG_W'($urandom);
      is_jump     = ($urandom % 4) == 0;
      jalr        = $urandom % 2;
      cmp_ctrl    = 3'($urandom);
      rs1_data    = $urandom;
      rs2_data    = ($urandom % 3 == 0) ? rs1_data : $urandom;
      imm         = ($urandom % 2) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
      pc          = $urandom;
      r           = ref_model(cur_op());
      pred_taken  = ($urandom % 2) ? r.tk : 1'($urandom);
      pred_target = ($urandom % 2) ? r.tgt : $urandom;
      step();
    end
    flush = 1'b0; issue_valid = 1'b0; done_ready = 1'b1;
    repeat (6) step();

    // Async reset while results are held, then latency of each build.
    done_ready = 1'b0;
    set_op(4'd11, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h1000, 1'b1, 32'h1040);
    issue_valid = 1'b1; step();
    issue_valid = 1'b0; step();
    chk("ar_pre_dv", done_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_dv", done_valid, 0);
    chk("ar_dv_l1", dv_l1, 0);
    chk("ar_dv_l4", dv_l4, 0);
    q_op.delete(); q_adv.delete(); delivered.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    done_ready = 1'b1;
    set_op(4'd12, 1'b0, 1'b1, 3'b010, 32'h3000, 32'h1, 32'h10, 32'h500, 1'b1, 32'h0);
    o = cur_op();
    r = ref_model(o);
    issue_valid = 1'b1; step();
    issue_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int k = 1; k <= 8; k++) begin
      if (dv_l1 && lat1 == 0) lat1 = k;
      if (done_valid && lat2 == 0) lat2 = k;
      if (dv_l4 && lat4 == 0) begin
        lat4 = k;
        chk("l4_tag", tag_l4, o.tag);
        chk("l4_target", pj_l4, r.tgt);
        chk("l4_mispred", mp_l4, r.mp);
      end
      step();
    end
    chk("lat_l1", lat1, 1);
    chk("lat_l2", lat2, 2);
    chk("lat_l4", lat4, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
